unidad_riesgos: RTL and testbench
=================================

// Module: unidad_riesgos
// PURPOSE
// - Stall/flush side of the pipeline's hazard handling; complements operand forwarding (MEM->EX, WB->EX).
// - Sits beside the ID stage. Detects dependences that forwarding cannot cover and freezes PC/IF_ID while inserting bubbles into ID_EX.
// - Flushes IF_ID on taken branches/jumps.
// - Drains the pipeline on HALT.
// - Keeps stall/flush performance counters for the debug unit.
// PARAMETERS
// - NB_REG    5   register index width
// - NB_CNT    32  performance counter width
// - DRAIN_CYC 3   cycles needed after HALT leaves ID before WB retires it
// PORTS
// - i_clk             in   1       clock
// - i_rst_n           in   1       asynchronous reset, active-low
// - i_rs_ID           in   NB_REG  rs of instruction in ID
// - i_rt_ID           in   NB_REG  rt of instruction in ID
// - i_uses_rs_ID      in   1       ID instruction reads rs
// - i_uses_rt_ID      in   1       ID instruction reads rt
// - i_branch_ID       in   1       ID instruction is BEQ/BNE/JR/JALR (operands compared/used in ID)
// - i_branch_taken    in   1       ID resolved a taken branch/jump this cycle
// - i_halt_ID         in   1       ID holds HALT
// - i_rd_EX           in   NB_REG  destination register in EX
// - i_write_reg_EX    in   1       EX instruction writes a register
// - i_mem_read_EX     in   1       EX instruction is a load
// - i_rd_MEM          in   NB_REG  destination register in MEM
// - i_mem_read_MEM    in   1       MEM instruction is a load
// - i_resume          in   1       debug: leave HALTED
// - i_clr_cnt         in   1       synchronous clear of both counters
// - o_stall_PC        out  1       hold PC
// - o_stall_IF_ID     out  1       hold IF_ID register
// - o_flush_ID_EX     out  1       load bubble (all control zero) into ID_EX
// - o_flush_IF_ID     out  1       replace IF_ID with NOP
// - o_halted          out  1       pipeline drained and frozen
// - o_stall_cnt       out  NB_CNT  cycles with hazard stall asserted
// - o_flush_cnt       out  NB_CNT  taken-branch flushes
// BEHAVIOUR
// - Match condition: dep(x, rd) = (x == rd) && (rd != 0) && uses_x.
// - Hazards (combinational, same cycle):
//   - LU = mem_read_EX && dep(rs|rt, rd_EX).
//   - BR1 = branch_ID && write_reg_EX && dep(rs|rt, rd_EX).
//   - BR2 = branch_ID && mem_read_MEM && dep(rs|rt, rd_MEM).
//   - haz = LU | BR1 | BR2.
//   - A branch on a load in EX therefore stalls 2 cycles (LU/BR1, then BR2).
// - FSM states:
//   - RUN: haz -> stall_PC = stall_IF_ID = flush_ID_EX = 1. Else if branch_taken -> flush_IF_ID = 1. Stall has priority: while haz, flush_IF_ID = 0.
//   - RUN -> DRAIN when i_halt_ID && !haz. In that cycle HALT advances to EX. Load drain counter with DRAIN_CYC-1.
//   - DRAIN: stall_PC = stall_IF_ID = flush_ID_EX = 1. Decrement each cycle. Go to HALTED at 0.
//   - HALTED: same freeze outputs, o_halted = 1. i_resume -> RUN the next cycle. IF_ID still holds HALT's successor; HALT itself has retired.
//   - i_resume is ignored outside HALTED.
// - Outputs:
//   - Stall/flush outputs are combinational from inputs and state; 0-cycle latency.
//   - o_halted is registered (decoded from state).
// - Counters:
//   - stall_cnt += 1 in each RUN cycle with haz. DRAIN/HALTED cycles are not counted.
//   - flush_cnt += 1 in each cycle where flush_IF_ID = 1.
//   - Both wrap at 2^NB_CNT.
//   - i_clr_cnt zeroes both next edge and wins over a same-cycle increment.
// - Reset (async, any time incl. mid-DRAIN):
//   - state = RUN, drain counter 0, counters 0, o_halted 0.
//   - Stall/flush outputs driven 0 while i_rst_n = 0.
// STRUCTURE
// - Shared package/header:
//   - state encoding RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2.
//   - register-zero constant.
//   - DRAIN_CYC default.
// - One sub-module natural: contador_perf (NB_CNT up-counter with inc/clr; clr wins), instantiated twice.
// - Hazard compare logic stays inline.
// TESTING
// - lw $2 in EX (rd = 2, mem_read = 1), ID add uses rs = 2 -> one cycle stall_PC = stall_IF_ID = flush_ID_EX = 1, then 0; stall_cnt = 1.
// - Same but rd_EX = 0, or ID does not use rs -> no stall.
// - beq rs = 3 in ID, lw $3 in EX -> stalls 2 consecutive cycles (BR1 then BR2); add $3 in EX -> exactly 1 cycle; stall_cnt += 2 / 1.
// - branch_taken = 1 with no hazard -> flush_IF_ID = 1 one cycle, flush_cnt = 1; branch_taken = 1 while BR1 active -> flush_IF_ID = 0, flush_cnt unchanged.
// - halt_ID = 1 -> freeze outputs for DRAIN_CYC cycles, o_halted = 1 the following cycle; i_resume -> RUN, outputs 0; resume pulsed in RUN -> ignored.
// - Reset mid-DRAIN -> RUN, counters 0, o_halted 0; i_clr_cnt coincident with increment -> counters read 0.

Source files
------------

// File: rtl/unidad_riesgos_pkg.sv
// Shared definitions for the hazard unit: FSM state encoding and common constants.
package unidad_riesgos_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } estado_t;

  localparam int REG_ZERO      = 0;
  localparam int DRAIN_CYC_DEF = 3;

endpackage

// File: rtl/unidad_riesgos_contador_perf.sv
// Wrapping performance up-counter; a clear request beats a same-cycle increment.
module contador_perf #(
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [NB_CNT-1:0] o_cnt
);

  logic [NB_CNT-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_inc) begin
      cnt_q <= cnt_q + NB_CNT'(1);
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/unidad_riesgos.sv
// Stall/flush hazard unit beside ID: load-use and branch-operand stalls, taken-branch
// flushes, HALT drain/freeze, and stall/flush performance counters.
module unidad_riesgos
  import unidad_riesgos_pkg::*;
#(
  parameter int NB_REG    = 5,
  parameter int NB_CNT    = 32,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NB_REG-1:0] i_rs_ID,
  input  logic [NB_REG-1:0] i_rt_ID,
  input  logic              i_uses_rs_ID,
  input  logic              i_uses_rt_ID,
  input  logic              i_branch_ID,
  input  logic              i_branch_taken,
  input  logic              i_halt_ID,
  input  logic [NB_REG-1:0] i_rd_EX,
  input  logic              i_write_reg_EX,
  input  logic              i_mem_read_EX,
  input  logic [NB_REG-1:0] i_rd_MEM,
  input  logic              i_mem_read_MEM,
  input  logic              i_resume,
  input  logic              i_clr_cnt,
  output logic              o_stall_PC,
  output logic              o_stall_IF_ID,
  output logic              o_flush_ID_EX,
  output logic              o_flush_IF_ID,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_stall_cnt,
  output logic [NB_CNT-1:0] o_flush_cnt
);

  localparam int NB_DRAIN = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYC - 1);
  localparam logic [NB_REG-1:0]   REG_Z      = NB_REG'(REG_ZERO);

  estado_t             state_q, state_d;
  logic [NB_DRAIN-1:0] drainCnt_q, drainCnt_d;
  logic                halted_q;

  logic depEx, depMem;
  logic hazLoadUse, hazBranchEx, hazBranchMem, haz;
  logic freeze, flushIfId, stallInc;

  // Dependence on EX/MEM destination; register zero never creates a dependence.
  assign depEx  = (i_rd_EX  != REG_Z) &&
                  ((i_uses_rs_ID && (i_rs_ID == i_rd_EX)) ||
                   (i_uses_rt_ID && (i_rt_ID == i_rd_EX)));
  assign depMem = (i_rd_MEM != REG_Z) &&
                  ((i_uses_rs_ID && (i_rs_ID == i_rd_MEM)) ||
                   (i_uses_rt_ID && (i_rt_ID == i_rd_MEM)));

  assign hazLoadUse   = i_mem_read_EX && depEx;
  assign hazBranchEx  = i_branch_ID && i_write_reg_EX && depEx;
  assign hazBranchMem = i_branch_ID && i_mem_read_MEM && depMem;
  assign haz          = hazLoadUse | hazBranchEx | hazBranchMem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RUN;
      drainCnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      halted_q   <= (state_d == HALTED);
    end
  end

  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    freeze     = 1'b0;
    flushIfId  = 1'b0;
    stallInc   = 1'b0;
    case (state_q)
      RUN: begin
        if (haz) begin
          freeze   = 1'b1;
          stallInc = 1'b1;
        end else begin
          flushIfId = i_branch_taken;
          if (i_halt_ID) begin
            state_d    = DRAIN;
            drainCnt_d = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        freeze = 1'b1;
        if (drainCnt_q == '0) begin
          state_d = HALTED;
        end else begin
          drainCnt_d = drainCnt_q - NB_DRAIN'(1);
        end
      end
      HALTED: begin
        freeze = 1'b1;
        if (i_resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d    = RUN;
        drainCnt_d = '0;
      end
    endcase
  end

  // Control outputs are forced low while reset is held, regardless of hazard inputs.
  assign o_stall_PC    = i_rst_n & freeze;
  assign o_stall_IF_ID = i_rst_n & freeze;
  assign o_flush_ID_EX = i_rst_n & freeze;
  assign o_flush_IF_ID = i_rst_n & flushIfId;
  assign o_halted      = halted_q;

  contador_perf #(.NB_CNT(NB_CNT)) u_cnt_stall (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (stallInc),
    .i_clr   (i_clr_cnt),
    .o_cnt   (o_stall_cnt)
  );

  contador_perf #(.NB_CNT(NB_CNT)) u_cnt_flush (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (flushIfId),
    .i_clr   (i_clr_cnt),
    .o_cnt   (o_flush_cnt)
  );

endmodule

// File: tb/tb_unidad_riesgos.sv
// Self-checking bench for unidad_riesgos: directed hazard/halt scenarios plus random traffic
// compared against a cycle-indexed behavioural model.
module tb_unidad_riesgos;

  localparam int NB_REG    = 5;
  localparam int NB_CNT    = 32;
  localparam int DRAIN_CYC = 3;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic       branch;
    logic       taken;
    logic       halt;
    logic [4:0] rdEx;
    logic       wrEx;
    logic       memEx;
    logic [4:0] rdMem;
    logic       memMem;
    logic       resume;
    logic       clr;
  } stim_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [NB_REG-1:0] rsId = '0, rtId = '0, rdEx = '0, rdMem = '0;
  logic usesRs = 1'b0, usesRt = 1'b0, branchId = 1'b0, branchTaken = 1'b0, haltId = 1'b0;
  logic writeRegEx = 1'b0, memReadEx = 1'b0, memReadMem = 1'b0, resume = 1'b0, clrCnt = 1'b0;
  logic stallPc, stallIfId, flushIdEx, flushIfId, halted;
  logic [NB_CNT-1:0] stallCnt, flushCnt;

  int compared = 0;
  int mismatched = 0;

  // Model state: the cycle index and the cycle in which HALT was accepted (-1 when running).
  int cyc = 0;
  int haltAt = -1;
  logic [31:0] mStallCnt = '0;
  logic [31:0] mFlushCnt = '0;

  always #5 clk = ~clk;

  unidad_riesgos #(.NB_REG(NB_REG), .NB_CNT(NB_CNT), .DRAIN_CYC(DRAIN_CYC)) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_rs_ID        (rsId),
    .i_rt_ID        (rtId),
    .i_uses_rs_ID   (usesRs),
    .i_uses_rt_ID   (usesRt),
    .i_branch_ID    (branchId),
    .i_branch_taken (branchTaken),
    .i_halt_ID      (haltId),
    .i_rd_EX        (rdEx),
    .i_write_reg_EX (writeRegEx),
    .i_mem_read_EX  (memReadEx),
    .i_rd_MEM       (rdMem),
    .i_mem_read_MEM (memReadMem),
    .i_resume       (resume),
    .i_clr_cnt      (clrCnt),
    .o_stall_PC     (stallPc),
    .o_stall_IF_ID  (stallIfId),
    .o_flush_ID_EX  (flushIdEx),
    .o_flush_IF_ID  (flushIfId),
    .o_halted       (halted),
    .o_stall_cnt    (stallCnt),
    .o_flush_cnt    (flushCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit dep(input logic [4:0] x, input logic [4:0] rd, input logic uses);
    return (uses == 1'b1) && (x == rd) && (rd != 5'd0);
  endfunction

  function automatic bit hazOf(input stim_t s);
    bit onEx, onMem;
    onEx  = dep(s.rs, s.rdEx, s.usesRs) || dep(s.rt, s.rdEx, s.usesRt);
    onMem = dep(s.rs, s.rdMem, s.usesRs) || dep(s.rt, s.rdMem, s.usesRt);
    return (s.memEx && onEx) || (s.branch && s.wrEx && onEx) || (s.branch && s.memMem && onMem);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic driveInputs(input stim_t s);
    rsId = s.rs;  rtId = s.rt;  usesRs = s.usesRs;  usesRt = s.usesRt;
    branchId = s.branch;  branchTaken = s.taken;  haltId = s.halt;
    rdEx = s.rdEx;  writeRegEx = s.wrEx;  memReadEx = s.memEx;
    rdMem = s.rdMem;  memReadMem = s.memMem;  resume = s.resume;  clrCnt = s.clr;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic applyStimulus(input stim_t s, input string tag);
    bit haz, running, haltedNow, eFreeze, eFlush;
    @(negedge clk);
    driveInputs(s);
    #1;
    haz       = hazOf(s);
    running   = (haltAt < 0);
    haltedNow = !running && (cyc >= haltAt + DRAIN_CYC + 1);
    eFreeze   = running ? haz : 1'b1;
    eFlush    = running && !haz && s.taken;
    checkOutput({tag, ".stall_PC"},    32'(stallPc),   32'(eFreeze));
    checkOutput({tag, ".stall_IF_ID"}, 32'(stallIfId), 32'(eFreeze));
    checkOutput({tag, ".flush_ID_EX"}, 32'(flushIdEx), 32'(eFreeze));
    checkOutput({tag, ".flush_IF_ID"}, 32'(flushIfId), 32'(eFlush));
    if (s.clr) begin
      mStallCnt = '0;
      mFlushCnt = '0;
    end else begin
      mStallCnt = mStallCnt + 32'(running && haz);
      mFlushCnt = mFlushCnt + 32'(eFlush);
    end
    if (running && s.halt && !haz) haltAt = cyc;
    else if (haltedNow && s.resume) haltAt = -1;
    cyc++;
    @(posedge clk);
    #1;
    checkOutput({tag, ".halted"},    32'(halted), 32'((haltAt >= 0) && (cyc >= haltAt + DRAIN_CYC + 1)));
    checkOutput({tag, ".stall_cnt"}, stallCnt, mStallCnt);
    checkOutput({tag, ".flush_cnt"}, flushCnt, mFlushCnt);
  endtask

  // Asynchronous reset asserted mid-cycle with a live hazard on the inputs.
  task automatic applyReset(input string tag);
    stim_t s;
    s = idle();
    s.memEx = 1'b1;  s.rdEx = 5'd4;  s.rs = 5'd4;  s.usesRs = 1'b1;  s.taken = 1'b1;
    @(negedge clk);
    driveInputs(s);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput({tag, ".stall_PC"},    32'(stallPc),   32'd0);
    checkOutput({tag, ".stall_IF_ID"}, 32'(stallIfId), 32'd0);
    checkOutput({tag, ".flush_ID_EX"}, 32'(flushIdEx), 32'd0);
    checkOutput({tag, ".flush_IF_ID"}, 32'(flushIfId), 32'd0);
    checkOutput({tag, ".halted"},      32'(halted),    32'd0);
    checkOutput({tag, ".stall_cnt"},   stallCnt,       32'd0);
    checkOutput({tag, ".flush_cnt"},   flushCnt,       32'd0);
    haltAt = -1;
    mStallCnt = '0;
    mFlushCnt = '0;
    @(negedge clk);
    driveInputs(idle());
    rstN = 1'b1;
  endtask

  initial begin
    stim_t s;

    applyReset("reset");

    // Load-use on rs, then released.
    s = idle();  s.memEx = 1'b1;  s.rdEx = 5'd2;  s.rs = 5'd2;  s.usesRs = 1'b1;
    applyStimulus(s, "lu");
    applyStimulus(idle(), "lu_after");
    checkOutput("lu_cnt", stallCnt, 32'd1);

    s.rdEx = 5'd0;  s.rs = 5'd0;
    applyStimulus(s, "lu_r0");
    s.rdEx = 5'd2;  s.rs = 5'd2;  s.usesRs = 1'b0;
    applyStimulus(s, "lu_nouse");
    s.usesRt = 1'b1;  s.rt = 5'd2;
    applyStimulus(s, "lu_rt");

    // Branch on a load: BR1 then BR2, then free.
    s = idle();  s.branch = 1'b1;  s.rs = 5'd3;  s.usesRs = 1'b1;
    s.rdEx = 5'd3;  s.wrEx = 1'b1;  s.memEx = 1'b1;
    applyStimulus(s, "br_lw1");
    s.rdEx = 5'd0;  s.wrEx = 1'b0;  s.memEx = 1'b0;  s.rdMem = 5'd3;  s.memMem = 1'b1;
    applyStimulus(s, "br_lw2");
    s.rdMem = 5'd0;  s.memMem = 1'b0;
    applyStimulus(s, "br_lw3");

    // Branch on an ALU result: one stall only.
    s = idle();  s.branch = 1'b1;  s.rt = 5'd3;  s.usesRt = 1'b1;  s.rdEx = 5'd3;  s.wrEx = 1'b1;
    applyStimulus(s, "br_add1");
    s.rdEx = 5'd0;  s.wrEx = 1'b0;  s.rdMem = 5'd3;  s.taken = 1'b1;
    applyStimulus(s, "br_add2");

    // Taken branch blocked by BR1.
    s = idle();  s.branch = 1'b1;  s.taken = 1'b1;  s.rs = 5'd7;  s.usesRs = 1'b1;
    s.rdEx = 5'd7;  s.wrEx = 1'b1;
    applyStimulus(s, "taken_haz");

    // HALT drain, frozen wait, ignored branch, resume, resume in RUN ignored.
    s = idle();  s.halt = 1'b1;
    applyStimulus(s, "halt");
    s = idle();  s.taken = 1'b1;
    for (int i = 0; i < DRAIN_CYC + 2; i++) applyStimulus(s, "drain");
    s = idle();  s.resume = 1'b1;
    applyStimulus(s, "resume");
    applyStimulus(s, "resume_run");
    applyStimulus(idle(), "run");

    // Reset while draining.
    s = idle();  s.halt = 1'b1;
    applyStimulus(s, "halt2");
    applyStimulus(idle(), "drain2");
    applyReset("rst_drain");

    // Clear coincident with increments.
    s = idle();  s.taken = 1'b1;
    applyStimulus(s, "pre_clr");
    s = idle();  s.memEx = 1'b1;  s.rdEx = 5'd5;  s.rt = 5'd5;  s.usesRt = 1'b1;  s.clr = 1'b1;
    applyStimulus(s, "clr_haz");
    s = idle();  s.taken = 1'b1;  s.clr = 1'b1;
    applyStimulus(s, "clr_flush");

    for (int i = 0; i < 600; i++) begin
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.usesRs = 1'($urandom_range(0, 1));
      s.usesRt = 1'($urandom_range(0, 1));
      s.branch = 1'($urandom_range(0, 1));
      s.taken  = 1'($urandom_range(0, 1));
      s.halt   = ($urandom_range(0, 15) == 0);
      s.rdEx   = 5'($urandom_range(0, 3));
      s.wrEx   = 1'($urandom_range(0, 1));
      s.memEx  = ($urandom_range(0, 2) == 0);
      s.rdMem  = 5'($urandom_range(0, 3));
      s.memMem = ($urandom_range(0, 2) == 0);
      s.resume = ($urandom_range(0, 3) == 0);
      s.clr    = ($urandom_range(0, 40) == 0);
      applyStimulus(s, "rand");
      if (i == 300) applyReset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
